// File: rtl/pwm_cmd_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pwm_cmd_parser
// Description : Parses ASCII commands arriving from a UART receiver and drives
//               the configuration inputs of pwm_ctrl. Every complete frame is
//               answered with 'K' (applied) or 'E' (rejected) over a
//               valid/ready handshake toward the UART transmitter.
//                 "Ddd<CR>" duty percent, "Fab<CR>" pow2/pow5 dividers,
//                 "R<CR>" clears all configuration. LF is ignored everywhere.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset
//               rx_data    - received byte, qualified by rx_valid
//               rx_valid   - single-cycle byte strobe
//               tx_data    - response byte ('K' / 'E')
//               tx_valid   - response byte available
//               tx_ready   - transmitter accepts byte when tx_valid && tx_ready
//               pow2_cfg   - divide-by-2^n setting
//               pow5_cfg   - divide-by-5^n setting
//               duty_cfg   - duty cycle in percent
//               cfg_valid  - one-cycle pulse, configuration just changed
//               cmd_err    - one-cycle pulse on error, timeout or dropped byte
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int DUTY_MAX       = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] pow2_cfg,
  output logic [1:0] pow5_cfg,
  output logic [6:0] duty_cfg,
  output logic       cfg_valid,
  output logic       cmd_err
);

  localparam logic [7:0] c_CR    = 8'h0D;
  localparam logic [7:0] c_LF    = 8'h0A;
  localparam logic [7:0] c_ACK_K = 8'h4B;
  localparam logic [7:0] c_ACK_E = 8'h45;
  localparam logic [7:0] c_OP_D  = 8'h44;
  localparam logic [7:0] c_OP_F  = 8'h46;
  localparam logic [7:0] c_OP_R  = 8'h52;

  // The timer only has to count up to TIMEOUT_CYCLES-1.
  localparam int                c_TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0]   c_TIMER_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]        c_DUTY_MAX   = 7'(DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARG1  = 3'd1,
    S_ARG2  = 3'd2,
    S_TERM  = 3'd3,
    S_SKIP  = 3'd4,
    S_APPLY = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_DUTY = 2'd0,
    OP_FREQ = 2'd1,
    OP_RST  = 2'd2
  } op_t;

  state_t          r_state,     w_state_nx;
  op_t             r_op,        w_op_nx;
  logic [3:0]      r_d1,        w_d1_nx;
  logic [3:0]      r_d0,        w_d0_nx;
  logic [1:0]      r_pow2,      w_pow2_nx;
  logic [1:0]      r_pow5,      w_pow5_nx;
  logic [6:0]      r_duty,      w_duty_nx;
  logic            r_cfg_valid, w_cfg_valid_nx;
  logic            r_cmd_err,   w_cmd_err_nx;
  logic [7:0]      r_tx_data,   w_tx_data_nx;
  logic [c_TW-1:0] r_timer,     w_timer_nx;

  logic       w_byte;
  logic       w_open;
  logic       w_expired;
  logic       w_is_dec;
  logic       w_is_quad;
  logic       w_arg_ok;
  logic [6:0] w_d1_7;
  logic [6:0] w_duty_val;
  logic       w_val_ok;

  // LF is invisible to the parser: it never counts as a byte.
  assign w_byte    = rx_valid && (rx_data != c_LF);
  assign w_open    = (r_state == S_ARG1) || (r_state == S_ARG2) ||
                     (r_state == S_TERM) || (r_state == S_SKIP);
  // A byte in the expiry cycle takes priority over the timeout.
  assign w_expired = w_open && !w_byte && (r_timer == c_TIMER_LAST);

  assign w_is_dec  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_is_quad = (rx_data >= 8'h30) && (rx_data <= 8'h33);
  assign w_arg_ok  = (r_op == OP_FREQ) ? w_is_quad : w_is_dec;

  // Digits are stored as the low nibble, which equals (byte - 0x30) for a
  // legal digit. 10*d1 = 8*d1 + 2*d1; the largest result is 99.
  assign w_d1_7     = {3'b000, r_d1};
  assign w_duty_val = (w_d1_7 << 3) + (w_d1_7 << 1) + {3'b000, r_d0};
  assign w_val_ok   = (r_op != OP_DUTY) || (w_duty_val <= c_DUTY_MAX);

  always_comb begin
    w_state_nx     = r_state;
    w_op_nx        = r_op;
    w_d1_nx        = r_d1;
    w_d0_nx        = r_d0;
    w_pow2_nx      = r_pow2;
    w_pow5_nx      = r_pow5;
    w_duty_nx      = r_duty;
    w_cfg_valid_nx = 1'b0;
    w_cmd_err_nx   = 1'b0;
    w_tx_data_nx   = r_tx_data;
    w_timer_nx     = '0;

    if (w_open && !w_byte) begin
      w_timer_nx = r_timer + c_TW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_byte) begin
          if (rx_data == c_OP_D) begin
            w_op_nx    = OP_DUTY;
            w_state_nx = S_ARG1;
          end else if (rx_data == c_OP_F) begin
            w_op_nx    = OP_FREQ;
            w_state_nx = S_ARG1;
          end else if (rx_data == c_OP_R) begin
            w_op_nx    = OP_RST;
            w_state_nx = S_TERM;
          end else if (rx_data != c_CR) begin
            w_state_nx = S_SKIP;
          end
        end
      end

      S_ARG1: begin
        if (w_byte) begin
          if (w_arg_ok) begin
            w_d1_nx    = rx_data[3:0];
            w_state_nx = S_ARG2;
          end else begin
            w_state_nx = S_SKIP;
          end
        end else if (w_expired) begin
          w_state_nx   = S_IDLE;
          w_cmd_err_nx = 1'b1;
        end
      end

      S_ARG2: begin
        if (w_byte) begin
          if (w_arg_ok) begin
            w_d0_nx    = rx_data[3:0];
            w_state_nx = S_TERM;
          end else begin
            w_state_nx = S_SKIP;
          end
        end else if (w_expired) begin
          w_state_nx   = S_IDLE;
          w_cmd_err_nx = 1'b1;
        end
      end

      S_TERM: begin
        if (w_byte) begin
          if (rx_data != c_CR) begin
            w_state_nx = S_SKIP;
          end else if (w_val_ok) begin
            // Configuration is committed here so it is visible in APPLY.
            w_state_nx     = S_APPLY;
            w_cfg_valid_nx = 1'b1;
            case (r_op)
              OP_DUTY: w_duty_nx = w_duty_val;
              OP_FREQ: begin
                w_pow2_nx = r_d1[1:0];
                w_pow5_nx = r_d0[1:0];
              end
              default: begin
                w_pow2_nx = 2'd0;
                w_pow5_nx = 2'd0;
                w_duty_nx = 7'd0;
              end
            endcase
          end else begin
            w_state_nx   = S_RESP;
            w_tx_data_nx = c_ACK_E;
            w_cmd_err_nx = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nx   = S_IDLE;
          w_cmd_err_nx = 1'b1;
        end
      end

      S_SKIP: begin
        if (w_byte) begin
          if (rx_data == c_CR) begin
            w_state_nx   = S_RESP;
            w_tx_data_nx = c_ACK_E;
            w_cmd_err_nx = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nx   = S_IDLE;
          w_cmd_err_nx = 1'b1;
        end
      end

      S_APPLY: begin
        w_state_nx   = S_RESP;
        w_tx_data_nx = c_ACK_K;
        w_cmd_err_nx = w_byte;
      end

      S_RESP: begin
        w_cmd_err_nx = w_byte;
        if (tx_ready) begin
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_DUTY;
      r_d1        <= 4'd0;
      r_d0        <= 4'd0;
      r_pow2      <= 2'd0;
      r_pow5      <= 2'd0;
      r_duty      <= 7'd0;
      r_cfg_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_tx_data   <= 8'h00;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_op        <= w_op_nx;
      r_d1        <= w_d1_nx;
      r_d0        <= w_d0_nx;
      r_pow2      <= w_pow2_nx;
      r_pow5      <= w_pow5_nx;
      r_duty      <= w_duty_nx;
      r_cfg_valid <= w_cfg_valid_nx;
      r_cmd_err   <= w_cmd_err_nx;
      r_tx_data   <= w_tx_data_nx;
      r_timer     <= w_timer_nx;
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = (r_state == S_RESP);
  assign pow2_cfg  = r_pow2;
  assign pow5_cfg  = r_pow5;
  assign duty_cfg  = r_duty;
  assign cfg_valid = r_cfg_valid;
  assign cmd_err   = r_cmd_err;

endmodule
`default_nettype wire

// File: doc/pwm_cmd_parser.md
# pwm_cmd_parser

UART-to-PWM configuration controller. Consumes received bytes from the UART receiver, parses short ASCII commands, and drives the `pow2_cfg`/`pow5_cfg`/`duty_cfg`/`cfg_valid` configuration inputs of `pwm_ctrl`. After each complete frame it returns a one-byte acknowledgement ('K' or 'E') to the UART transmitter over a valid/ready handshake.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte timeout in `clk` cycles while a frame is open.
- `DUTY_MAX`, default 99: largest accepted duty value. Larger values are rejected with 'E'.

Ports:

- `clk`  in  1: system clock. The block uses this single clock only.
- `rst`  in  1: reset, synchronous and active-high.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: single-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data`  out  8: response byte.
- `tx_valid`  out  1: response byte available.
- `tx_ready`  in  1: transmitter accepts the byte in any cycle where `tx_valid && tx_ready`.
- `pow2_cfg`  out  2: to `pwm_ctrl`; divide by 2^n.
- `pow5_cfg`  out  2: to `pwm_ctrl`; divide by 5^n.
- `duty_cfg`  out  7: to `pwm_ctrl`; duty in percent, 0..DUTY_MAX.
- `cfg_valid`  out  1: one-cycle pulse, config outputs are new.
- `cmd_err`  out  1: one-cycle pulse on any protocol error, timeout or dropped byte.

## Operation

Grammar (uppercase ASCII only; CR = 0x0D):

- `D d1 d0 CR`: `duty_cfg` = 10·d1 + d0, where d1 and d0 are '0'..'9'.
- `F a b CR`: `pow2_cfg` = a, `pow5_cfg` = b, where a and b are '0'..'3'.
- `R CR`: all three config outputs go to 0.

Byte filtering:

- LF (0x0A) is ignored in every state. It never advances state, never errors and never reloads the timer.
- CR received in IDLE is ignored (no reply).

State machine:

- States: IDLE, ARG1, ARG2, TERM, SKIP, APPLY, RESP.
- IDLE: 'D' or 'F' → ARG1 (latch the opcode); 'R' → TERM; any other byte → SKIP.
- ARG1: legal digit → ARG2 (latch the digit); otherwise → SKIP.
- ARG2: legal digit → TERM; otherwise → SKIP.
- TERM: CR → APPLY if the value is legal, else → RESP with 'E'. Any other byte → SKIP.
- SKIP: discard bytes until CR, then → RESP with 'E'.
- APPLY: one cycle, then → RESP with 'K'.
- RESP: hold `tx_valid` until handshake, then → IDLE.

Arithmetic: compute 10·d1 as (d1<<3)+(d1<<1) on the 7-bit value of (byte − 0x30). Maximum result is 99, so there is no overflow. A D frame with value > DUTY_MAX is an error: reply 'E', `cmd_err` pulses, outputs unchanged.

Each config output is updated only by its own command: D leaves pow2/pow5 untouched, F leaves duty untouched.

Error handling:

- `cmd_err` pulses once when a frame resolves to 'E'.
- Timeout: in ARG1, ARG2, TERM or SKIP, if `TIMEOUT_CYCLES` cycles pass with no non-LF byte → IDLE, `cmd_err` pulses, no reply.
- Bytes arriving in RESP or APPLY are dropped; `cmd_err` pulses for each.

## Timing

- Reset values: `pow2_cfg`=0, `pow5_cfg`=0, `duty_cfg`=0, `cfg_valid`=0, `tx_valid`=0, `tx_data`=0x00, `cmd_err`=0. State resets to IDLE and the timer clears.
- Reset mid-frame or in RESP: the partial frame is discarded. `tx_valid` drops on the next edge even if the byte was not accepted.
- Terminating CR accepted in cycle N (`rx_valid`=1):
  - Cycle N+1 (APPLY): new config visible, `cfg_valid`=1.
  - Cycle N+2: `tx_valid`=1, `tx_data`=0x4B.
- Error CR in cycle N: `tx_valid`=1, `tx_data`=0x45 and `cmd_err`=1, all from cycle N+1.
- `tx_data` is stable while `tx_valid`=1. The handshake completes on the first edge with `tx_ready`=1; `tx_valid`=0 and state is IDLE from the next cycle. `tx_ready` while `tx_valid`=0 is ignored.
- Timer: reloads on every accepted non-LF byte. It expires when the count reaches `TIMEOUT_CYCLES`. If `rx_valid` arrives in the expiry cycle, the byte wins: it is processed and the timer reloads.
- `cfg_valid` and `cmd_err` are single-cycle pulses that never stretch.

## Test plan

- Send "D25\r" → `duty_cfg`=25, `cfg_valid` high exactly one cycle, pow2/pow5 stay 0, then `tx_data`=0x4B with one handshake.
- Send "F21\r" → `pow2_cfg`=2, `pow5_cfg`=1, `duty_cfg` unchanged at 25, reply 'K'. Then send "F40\r" → reply 'E', `cmd_err` pulse, config unchanged.
- Send "D7X\r\n" → no `cfg_valid`, reply 0x45, `cmd_err` one pulse, LF ignored. Then "D99\r" → `duty_cfg`=99. With `DUTY_MAX`=50, "D51\r" → 'E' and `duty_cfg` unchanged.
- With `TIMEOUT_CYCLES`=100: send "D9" and idle 100 cycles → `cmd_err` pulse, no reply. Then "D10\r" → `duty_cfg`=10 and 'K'.
- Hold `tx_ready`=0 for 20 cycles after 'K' → `tx_valid` and `tx_data` stable, and a byte sent meanwhile gives a `cmd_err` pulse and is dropped. Then raise `tx_ready` → exactly one handshake, after which the FSM is back in IDLE.
- Send "D5", then assert `rst` for 1 cycle → all outputs at reset values. A following lone "\r" gives no reply. Then "R\r" → all config 0, `cfg_valid` pulse, reply 'K'.
